// File: rtl/rc5_dec_16bit_if.sv
`default_nettype none
// ============================================================================
// Module   : rc5_dec_16bit_if
// Brief    : Start/done handshake and data bus for the 16-bit RC5 decryptor.
// Revision : 1.0 - initial release
// ============================================================================
interface rc5_dec_16bit_if;
   logic        dec_start;
   logic [15:0] c;
   logic [15:0] p;
   logic        dec_done;
   logic        busy;

   modport master (
      output dec_start,
      output c,
      input  p,
      input  dec_done,
      input  busy
   );

   modport slave (
      input  dec_start,
      input  c,
      output p,
      output dec_done,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/rc5_dec_16bit.sv
`default_nettype none
// ============================================================================
// Module   : rc5_dec_16bit
// Brief    : One-round 16-bit RC5 decryptor (8-bit halves, 4-entry S table)
//            with a start/done handshake; inverse of the paired encryptor.
// Revision : 1.0 - initial release
// ============================================================================
module rc5_dec_16bit #(
   parameter logic [7:0] S0 = 8'h20,
   parameter logic [7:0] S1 = 8'h10,
   parameter logic [7:0] S2 = 8'hFF,
   parameter logic [7:0] S3 = 8'hFF
) (
   input  wire            clock,
   input  wire            reset,
   rc5_dec_16bit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UNB  = 3'd1,
      UNA  = 3'd2,
      UNW  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [7:0]  w_a_nxt;
   logic [7:0]  w_b_nxt;
   logic [15:0] r_p;
   logic [15:0] w_p_nxt;
   logic        r_done;
   logic        w_done_nxt;
   logic        r_busy;
   logic        w_busy_nxt;

   // True 8-bit rotate: a zero amount returns x untouched.
   function automatic logic [7:0] ror8(input logic [7:0] x, input logic [2:0] n);
      logic [15:0] w_dbl;
      w_dbl = {x, x} >> n;
      return w_dbl[7:0];
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_a    <= 8'h00;
         r_b    <= 8'h00;
         r_p    <= 16'h0000;
         r_done <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_a    <= w_a_nxt;
         r_b    <= w_b_nxt;
         r_p    <= w_p_nxt;
         r_done <= w_done_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_p_nxt     = r_p;
      w_done_nxt  = r_done;
      w_busy_nxt  = r_busy;
      case (r_state)
         IDLE: begin
            if (bus.dec_start) begin
               w_a_nxt     = bus.c[15:8];
               w_b_nxt     = bus.c[7:0];
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b0;
               w_state_nxt = UNB;
            end
         end
         UNB: begin
            w_b_nxt     = ror8(r_b - S3, r_a[2:0]) ^ r_a;
            w_state_nxt = UNA;
         end
         UNA: begin
            // B already holds its un-rounded value from UNB.
            w_a_nxt     = ror8(r_a - S2, r_b[2:0]) ^ r_b;
            w_state_nxt = UNW;
         end
         UNW: begin
            w_p_nxt     = {r_a - S0, r_b - S1};
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = DONE;
         end
         DONE: begin
            // A held-high start must be released before the next word.
            if (!bus.dec_start) begin
               w_done_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.p        = r_p;
   assign bus.dec_done = r_done;
   assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rc5_dec_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc5_dec_16bit
// Brief    : Directed and randomized loopback bench for rc5_dec_16bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc5_dec_16bit;

   localparam logic [7:0] c_s0 = 8'h20;
   localparam logic [7:0] c_s1 = 8'h10;
   localparam logic [7:0] c_s2 = 8'hFF;
   localparam logic [7:0] c_s3 = 8'hFF;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rc5_dec_16bit_if bus ();

   rc5_dec_16bit #(
      .S0(c_s0), .S1(c_s1), .S2(c_s2), .S3(c_s3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic int rotl(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 255;
   endfunction

   // Reference encryptor: whitening then one RC5 round, all mod 256.
   function automatic logic [15:0] enc(input logic [15:0] x);
      int a;
      int b;
      a = (int'(x[15:8]) + int'(c_s0)) % 256;
      b = (int'(x[7:0])  + int'(c_s1)) % 256;
      a = (rotl(a ^ b, b % 8) + int'(c_s2)) % 256;
      b = (rotl(b ^ a, a % 8) + int'(c_s3)) % 256;
      return {a[7:0], b[7:0]};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Enters and leaves at a falling edge with the block in IDLE and start low.
   task automatic run_word(input string tag, input logic [15:0] cw, input logic [15:0] exp,
                           input bit scramble);
      bus.dec_start = 1'b1;
      bus.c         = cw;
      @(negedge clock);
      check({tag, "_busy_t0"}, 16'(bus.busy), 16'h1);
      check({tag, "_done_t0"}, 16'(bus.dec_done), 16'h0);
      if (scramble) begin
         bus.c         = 16'($urandom);
         bus.dec_start = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      @(negedge clock);
      check({tag, "_busy_t2"}, 16'(bus.busy), 16'h1);
      @(negedge clock);
      check({tag, "_done"}, 16'(bus.dec_done), 16'h1);
      check({tag, "_busy_end"}, 16'(bus.busy), 16'h0);
      check({tag, "_p"}, bus.p, exp);
      bus.dec_start = 1'b0;
      @(negedge clock);
      check({tag, "_done_clr"}, 16'(bus.dec_done), 16'h0);
      check({tag, "_p_hold"}, bus.p, exp);
   endtask

   initial begin
      logic [15:0] pt;
      bus.dec_start = 1'b0;
      bus.c         = 16'h0000;

      @(negedge clock);
      @(negedge clock);
      check("rst_p", bus.p, 16'h0000);
      check("rst_done", 16'(bus.dec_done), 16'h0);
      check("rst_busy", 16'(bus.busy), 16'h0);
      check("enc_vec0", enc(16'h0000), 16'h2F9E);
      check("enc_vec1", enc(16'h1234), 16'h6687);

      // First word, start held high through DONE: no relaunch allowed.
      reset         = 1'b1;
      @(negedge clock);
      bus.dec_start = 1'b1;
      bus.c         = 16'h2F9E;
      @(negedge clock);
      check("w0_busy_t0", 16'(bus.busy), 16'h1);
      @(negedge clock);
      check("w0_busy_t1", 16'(bus.busy), 16'h1);
      @(negedge clock);
      check("w0_busy_t2", 16'(bus.busy), 16'h1);
      check("w0_done_t2", 16'(bus.dec_done), 16'h0);
      @(negedge clock);
      check("w0_done", 16'(bus.dec_done), 16'h1);
      check("w0_busy_end", 16'(bus.busy), 16'h0);
      check("w0_p", bus.p, 16'h0000);
      bus.c = 16'h6687;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("hold_done", 16'(bus.dec_done), 16'h1);
         check("hold_busy", 16'(bus.busy), 16'h0);
         check("hold_p", bus.p, 16'h0000);
      end
      bus.dec_start = 1'b0;
      @(negedge clock);
      check("drop_done", 16'(bus.dec_done), 16'h0);
      run_word("w1", 16'h6687, 16'h1234, 1'b0);
      run_word("rot0", 16'h2F9E, 16'h0000, 1'b0);
      run_word("w2", 16'h6687, 16'h1234, 1'b0);

      // Asynchronous abort while the A half is being processed.
      bus.dec_start = 1'b1;
      bus.c         = 16'h2F9E;
      @(negedge clock);
      bus.dec_start = 1'b0;
      @(negedge clock);
      check("pre_abort_busy", 16'(bus.busy), 16'h1);
      reset = 1'b0;
      #1;
      check("abort_p", bus.p, 16'h0000);
      check("abort_done", 16'(bus.dec_done), 16'h0);
      check("abort_busy", 16'(bus.busy), 16'h0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("post_abort_idle", 16'(bus.busy), 16'h0);
      run_word("w3", 16'h6687, 16'h1234, 1'b0);

      // Loopback against the reference encryptor.
      for (int k = 0; k < 1000; k++) begin
         pt = 16'($urandom);
         run_word("loop", enc(pt), pt, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
